cycle_timer: RTL and testbench

CYCLE_TIMER -- requirements
Module: cycle_timer

---
 rtl/tb4004_pkg.sv | 23 ++
 rtl/tick_watchdog.sv | 41 ++++
 rtl/cycle_timer.sv | 120 ++++++++++++
 tb/tb_cycle_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tb4004_pkg.sv
// Shared phase encoding and watchdog width for the machine-cycle timer.
// Phases run A1..X3 (0..7); one machine cycle is eight phases.
package tb4004_pkg;

  localparam int PH_W = 3;
  localparam int WD_W = 24;

  typedef enum logic [PH_W-1:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  function automatic logic [7:0] phase_onehot(input phase_e p);
    return 8'b0000_0001 << p;
  endfunction

endpackage

// File: rtl/tick_watchdog.sv
// Tick watchdog: counts running clocks since the last tick, saturating at limit.
// expired is a registered sticky flag, set the clock after the count sits at limit; limit==0 disables it.
module tick_watchdog
  import tb4004_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            run,
  input  logic [WD_W-1:0] limit,
  output logic            expired
);

  logic [WD_W-1:0] cnt_q, cnt_d;
  logic            expired_q, expired_d;

  // A tick always wins over a count already at the limit.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (tick) begin
      cnt_d = '0;
    end else if (run) begin
      if ((limit != '0) && (cnt_q == limit)) expired_d = 1'b1;
      if (cnt_q < limit) cnt_d = cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/cycle_timer.sv
// Machine-cycle phase sequencer: advances A1..X3 one clock after each tick while run; all outputs registered.
// Optional single-step parking at A1 is built only when SINGLE_STEP_EN is defined.
module cycle_timer
  import tb4004_pkg::*;
#(
  parameter logic [WD_W-1:0] TICK_TIMEOUT = 24'hFFFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            run,
`ifdef SINGLE_STEP_EN
  input  logic            stepMode,
  input  logic            stepReq,
  output logic            stepAck,
`endif
  output logic [PH_W-1:0] phase,
  output logic [7:0]      phaseOneHot,
  output logic            sync,
  output logic            cycleEnd,
  output logic [15:0]     cycleCount,
  output logic            tickLost
);

  phase_e      state_q, state_d;
  logic [7:0]  onehot_q, onehot_d;
  logic        sync_q, sync_d;
  logic        end_q, end_d;
  logic [15:0] count_q, count_d;
  logic        parked;
  logic        adv;

  assign adv = tick && run && !parked;

`ifdef SINGLE_STEP_EN
  logic granted_q, granted_d;
  logic req_prev_q;
  logic ack_q;
  logic grant;

  // Parked at A1 until a fresh stepReq rising level is seen; the grant is consumed when A1 is left.
  assign parked = stepMode && (state_q == PH_A1) && !granted_q;
  assign grant  = parked && stepReq && !req_prev_q;

  always_comb begin
    granted_d = granted_q;
    if (grant) begin
      granted_d = 1'b1;
    end else if (adv && (state_q == PH_A1)) begin
      granted_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      granted_q  <= 1'b0;
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      granted_q  <= granted_d;
      req_prev_q <= stepReq;
      ack_q      <= grant;
    end
  end

  assign stepAck = ack_q;
`else
  assign parked = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    sync_d   = sync_q;
    end_d    = 1'b0;
    count_d  = count_q;
    if (adv) begin
      state_d  = phase_e'(state_q + 3'd1);
      onehot_d = phase_onehot(state_d);
      sync_d   = (state_d == PH_X3);
      if (state_q == PH_X3) begin
        end_d   = 1'b1;
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PH_A1;
      onehot_q <= 8'h01;
      sync_q   <= 1'b0;
      end_q    <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      sync_q   <= sync_d;
      end_q    <= end_d;
      count_q  <= count_d;
    end
  end

  // Parking counts as activity so the watchdog stays cleared while waiting for a step.
  tick_watchdog u_wd (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick || parked),
    .run     (run),
    .limit   (TICK_TIMEOUT),
    .expired (tickLost)
  );

  assign phase       = state_q;
  assign phaseOneHot = onehot_q;
  assign sync        = sync_q;
  assign cycleEnd    = end_q;
  assign cycleCount  = count_q;

endmodule

// File: tb/tb_cycle_timer.sv
// Bench for cycle_timer with TICK_TIMEOUT=10; reference model tracks phase, cycle count and idle time.
module tb_cycle_timer;

  localparam logic [23:0] TO = 24'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        run = 1'b0;
  logic [2:0]  phase;
  logic [7:0]  phaseOneHot;
  logic        sync;
  logic        cycleEnd;
  logic [15:0] cycleCount;
  logic        tickLost;
`ifdef SINGLE_STEP_EN
  logic        stepMode = 1'b0;
  logic        stepReq = 1'b0;
  logic        stepAck;
`endif

  always #5 clk = ~clk;

  cycle_timer #(.TICK_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .run         (run),
`ifdef SINGLE_STEP_EN
    .stepMode    (stepMode),
    .stepReq     (stepReq),
    .stepAck     (stepAck),
`endif
    .phase       (phase),
    .phaseOneHot (phaseOneHot),
    .sync        (sync),
    .cycleEnd    (cycleEnd),
    .cycleCount  (cycleCount),
    .tickLost    (tickLost)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase index, completed cycles, clocks run without a tick.
  int m_phase = 0;
  int m_count = 0;
  int m_idle  = 0;
  bit m_end   = 1'b0;
  bit m_lost  = 1'b0;

  task automatic cyc(input bit r_st, input bit t, input bit r);
    rst  = r_st;
    tick = t;
    run  = r;
    @(posedge clk);
    if (r_st) begin
      m_phase = 0; m_count = 0; m_idle = 0; m_end = 1'b0; m_lost = 1'b0;
    end else begin
      m_end = 1'b0;
      if (t && r) begin
        if (m_phase == 7) begin
          m_end   = 1'b1;
          m_count = (m_count + 1) % 65536;
        end
        m_phase = (m_phase + 1) % 8;
      end
      if (t) begin
        m_idle = 0;
      end else if (r) begin
        if (TO != 0 && m_idle == int'(TO)) m_lost = 1'b1;
        if (m_idle < int'(TO)) m_idle++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", phase); end
    n_checks++; if (phaseOneHot !== 8'h01) begin n_fail++; $display("FAIL reset_onehot got %h want 01", phaseOneHot); end
    n_checks++; if (sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync got %b want 0", sync); end
    n_checks++; if (cycleEnd !== 1'b0) begin n_fail++; $display("FAIL reset_cycleEnd got %b want 0", cycleEnd); end
    n_checks++; if (cycleCount !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cycleCount); end
    n_checks++; if (tickLost !== 1'b0) begin n_fail++; $display("FAIL reset_tickLost got %b want 0", tickLost); end
`ifdef SINGLE_STEP_EN
    n_checks++; if (stepAck !== 1'b0) begin n_fail++; $display("FAIL reset_stepAck got %b want 0", stepAck); end
`endif
  endtask

  task automatic test_sequence();
    int ends = 0;
    int sync_clks = 0;
    cyc(1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      for (int k = 0; k < 3; k++) begin
        cyc(0, 0, 1);
        if (sync === 1'b1) sync_clks++;
        if (cycleEnd === 1'b1) ends++;
      end
      cyc(0, 1, 1);
      if (sync === 1'b1) sync_clks++;
      if (cycleEnd === 1'b1) ends++;
      n_checks++; if (phase !== 3'(i % 8)) begin n_fail++; $display("FAIL seq_phase tick %0d got %0d want %0d", i, phase, i % 8); end
      n_checks++; if (phaseOneHot !== 8'(1 << (i % 8))) begin n_fail++; $display("FAIL seq_onehot tick %0d got %h", i, phaseOneHot); end
    end
    n_checks++; if (ends != 2) begin n_fail++; $display("FAIL seq_cycleEnd_pulses got %0d want 2", ends); end
    n_checks++; if (cycleCount !== 16'd2) begin n_fail++; $display("FAIL seq_count got %0d want 2", cycleCount); end
    n_checks++; if (sync_clks != 8) begin n_fail++; $display("FAIL seq_sync_clocks got %0d want 8", sync_clks); end
  endtask

  task automatic test_run_gate();
    for (int i = 0; i < 3; i++) cyc(0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      n_checks++; if (phase !== 3'd3) begin n_fail++; $display("FAIL gate_phase got %0d want 3", phase); end
      n_checks++; if (cycleCount !== 16'd2) begin n_fail++; $display("FAIL gate_count got %0d want 2", cycleCount); end
    end
    cyc(0, 1, 1);
    n_checks++; if (phase !== 3'd4) begin n_fail++; $display("FAIL gate_resume got %0d want 4", phase); end
  endtask

  task automatic test_watchdog();
    cyc(1, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      cyc(0, 0, 1);
      n_checks++; if (tickLost !== (k >= 11)) begin n_fail++; $display("FAIL wd_timeout clk %0d got %b want %b", k, tickLost, k >= 11); end
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 1);
      n_checks++; if (tickLost !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b want 1", tickLost); end
    end
    n_checks++; if (phase !== 3'd4) begin n_fail++; $display("FAIL wd_phase got %0d want 4", phase); end
    cyc(1, 0, 0);
    for (int k = 1; k <= 10; k++) cyc(0, 0, 1);
    cyc(0, 1, 1);
    n_checks++; if (tickLost !== 1'b0) begin n_fail++; $display("FAIL wd_tick_at_limit got %b want 0", tickLost); end
    for (int k = 0; k < 5; k++) cyc(0, 0, 1);
    n_checks++; if (tickLost !== 1'b0) begin n_fail++; $display("FAIL wd_after_clear got %b want 0", tickLost); end
  endtask

  task automatic test_wrap();
    cyc(1, 0, 0);
    dut.count_q = 16'hFFFF;
    m_count     = 65535;
    for (int i = 0; i < 7; i++) cyc(0, 1, 1);
    n_checks++; if (cycleCount !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", cycleCount); end
    cyc(0, 1, 1);
    n_checks++; if (cycleCount !== 16'h0000) begin n_fail++; $display("FAIL wrap_count got %h want 0000", cycleCount); end
    n_checks++; if (cycleEnd !== 1'b1) begin n_fail++; $display("FAIL wrap_cycleEnd got %b want 1", cycleEnd); end
    n_checks++; if (tickLost !== 1'b0) begin n_fail++; $display("FAIL wrap_tickLost got %b want 0", tickLost); end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1);
    n_checks++; if (phase !== 3'd4) begin n_fail++; $display("FAIL mid_at_M2 got %0d want 4", phase); end
    cyc(1, 1, 1);
    n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL mid_phase got %0d want 0", phase); end
    n_checks++; if (phaseOneHot !== 8'h01) begin n_fail++; $display("FAIL mid_onehot got %h want 01", phaseOneHot); end
    n_checks++; if ({sync, cycleEnd, tickLost} !== 3'b000) begin n_fail++; $display("FAIL mid_flags got %b want 000", {sync, cycleEnd, tickLost}); end
    n_checks++; if (cycleCount !== 16'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", cycleCount); end
    cyc(0, 1, 1);
    n_checks++; if (phase !== 3'd1) begin n_fail++; $display("FAIL mid_resume got %0d want 1", phase); end
  endtask

  task automatic test_random();
    int tick_pct;
    cyc(1, 0, 0);
    for (int seg = 0; seg < 8; seg++) begin
      tick_pct = (seg % 2 == 0) ? 40 : 4;
      for (int i = 0; i < 60; i++) begin
        cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < tick_pct, $urandom_range(0, 99) < 80);
        n_checks++; if (phase !== 3'(m_phase)) begin n_fail++; $display("FAIL rnd_phase got %0d want %0d", phase, m_phase); end
        n_checks++; if (phaseOneHot !== 8'(1 << m_phase)) begin n_fail++; $display("FAIL rnd_onehot got %h want phase %0d", phaseOneHot, m_phase); end
        n_checks++; if (sync !== (m_phase == 7)) begin n_fail++; $display("FAIL rnd_sync got %b want %b", sync, m_phase == 7); end
        n_checks++; if (cycleEnd !== m_end) begin n_fail++; $display("FAIL rnd_cycleEnd got %b want %b", cycleEnd, m_end); end
        n_checks++; if (cycleCount !== 16'(m_count)) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", cycleCount, m_count); end
        n_checks++; if (tickLost !== m_lost) begin n_fail++; $display("FAIL rnd_tickLost got %b want %b", tickLost, m_lost); end
      end
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    int acks = 0;
    int ends = 0;
    stepMode = 1'b1;
    stepReq  = 1'b0;
    cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1);
      n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL step_parked got %0d want 0", phase); end
    end
    stepReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      if (stepAck === 1'b1) acks++;
    end
    stepReq = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 1);
      if (stepAck === 1'b1) acks++;
      if (cycleEnd === 1'b1) ends++;
      n_checks++; if (phase !== 3'(i % 8)) begin n_fail++; $display("FAIL step_cycle tick %0d got %0d want %0d", i, phase, i % 8); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1);
      if (stepAck === 1'b1) acks++;
      n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL step_reparked got %0d want 0", phase); end
    end
    n_checks++; if (acks != 1) begin n_fail++; $display("FAIL step_acks got %0d want 1", acks); end
    n_checks++; if (ends != 1) begin n_fail++; $display("FAIL step_ends got %0d want 1", ends); end
    n_checks++; if (tickLost !== 1'b0) begin n_fail++; $display("FAIL step_tickLost got %b want 0", tickLost); end
    stepMode = 1'b0;
    cyc(0, 1, 1);
    n_checks++; if (phase !== 3'd1) begin n_fail++; $display("FAIL step_release got %0d want 1", phase); end
    cyc(1, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_run_gate();
    test_watchdog();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef SINGLE_STEP_EN
    test_step();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
